// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths, sample types and clamp limits for the IIR output quantizer
package iir_pkg;

    localparam int DEF_IN_W       = 64;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_FRAC_SHIFT = 16;

    typedef logic signed [DEF_IN_W-1:0]  iir_in_t;
    typedef logic signed [DEF_OUT_W-1:0] iir_out_t;

    localparam iir_out_t OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam iir_out_t OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/iir_output_quantizer_if.sv
// rtl/iir_output_quantizer_if.sv - filter-sample input and quantized-sample output handshakes
interface iir_output_quantizer_if #(
    parameter int IN_W  = iir_pkg::DEF_IN_W,
    parameter int OUT_W = iir_pkg::DEF_OUT_W
) ();

    logic                    in_valid;
    logic signed [IN_W-1:0]  data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] data_out;

    // Quantizer side: consumes filter samples, produces the output stream.
    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output out_valid,
        output data_out
    );

    // Environment side: the filter feeding us and the sink draining us.
    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  out_valid,
        input  data_out
    );

endinterface

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - synchronous FIFO with occupancy, push accepted when full if a pop frees a slot
module iir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written, head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iir_output_quantizer.sv
// rtl/iir_output_quantizer.sv - round, saturate and buffer 64-bit filter output into 16-bit samples
module iir_output_quantizer
    import iir_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    iir_output_quantizer_if.slave        bus,
    input  logic                         clr_stats,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]             sat_count,
    output logic [CNT_W-1:0]             drop_count
);

    // Half an output LSB, so the arithmetic shift below rounds ties toward +inf.
    localparam logic signed [IN_W:0] ROUND = ((IN_W+1)'(1) << FRAC_SHIFT) >> 1;
    // Clamp limits expressed at the widened stage-1 width for a direct signed compare.
    localparam logic signed [IN_W:0] Q_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] Q_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]     SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    logic                    s1_valid;
    logic signed [IN_W:0]    s1_r;
    logic signed [IN_W:0]    q;
    logic                    q_hi;
    logic                    q_lo;
    logic [OUT_W-1:0]        q_sat;
    logic                    s2_valid;
    logic [OUT_W-1:0]        s2_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic [OUT_W-1:0]        head;

    // Stage 1: add the rounding constant one bit wider so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_r     <= $signed({bus.data_in[IN_W-1], bus.data_in}) + ROUND;
        end
    end

    // Drop the fractional bits and clamp to the signed output range.
    always_comb begin
        q     = s1_r >>> FRAC_SHIFT;
        q_hi  = (q > Q_MAX);
        q_lo  = (q < Q_MIN);
        q_sat = q[OUT_W-1:0];
        if (q_hi) begin
            q_sat = SAT_HI;
        end else if (q_lo) begin
            q_sat = SAT_LO;
        end
    end

    // Stage 2: register the quantized sample for the FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_data  <= q_sat;
        end
    end

    assign pop  = bus.out_valid & bus.out_ready;
    assign drop = s2_valid & fifo_full & ~pop;

    iir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid),
        .push_data (s2_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.data_out  = head;

    // Saturation counter: counted as the sample enters stage 2, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_count <= '0;
        end else if (s1_valid && (q_hi || q_lo) && sat_count != CNT_MAX) begin
            sat_count <= sat_count + 1'b1;
        end
    end

    // Drop counter: samples refused by a full FIFO, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            drop_count <= '0;
        end else if (drop && drop_count != CNT_MAX) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_iir_output_quantizer.sv
// tb/tb_iir_output_quantizer.sv - directed self-checking bench for iir_output_quantizer
module tb_iir_output_quantizer;

    logic        clk;
    logic        rst;
    logic        clr_stats;
    logic [3:0]  fifo_level;
    logic [15:0] sat_count;
    logic [15:0] drop_count;

    int checks;
    int failures;

    iir_output_quantizer_if bus ();

    iir_output_quantizer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_stats  (clr_stats),
        .fifo_level (fifo_level),
        .sat_count  (sat_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample, wait out the 3-cycle latency, then check the head.
    task automatic send_one(input string tag, input logic [63:0] din, input logic [15:0] exp);
        bus.in_valid = 1'b1;
        bus.data_in  = din;
        step();
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_early"}, {63'd0, bus.out_valid}, 64'd0);
        step();
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_data"}, {48'd0, $unsigned(bus.data_out)}, {48'd0, exp});
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        clr_stats    = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_level", {60'd0, fifo_level}, 64'd0);
        chk("rst_sat", {48'd0, sat_count}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        chk("rst_data", {48'd0, $unsigned(bus.data_out)}, 64'd0);

        // Rounding
        bus.out_ready = 1'b1;
        send_one("rnd_pos", 64'h0000_0000_0012_8000, 16'h0013);
        chk("rnd_pos_sat", {48'd0, sat_count}, 64'd0);
        send_one("rnd_m05", 64'hFFFF_FFFF_FFFF_8000, 16'h0000);
        send_one("rnd_m15", 64'hFFFF_FFFF_FFFE_8000, 16'hFFFF);

        // Saturation and stats clear
        send_one("sat_hi", 64'h0000_0000_8000_0000, 16'h7FFF);
        chk("sat_hi_cnt", {48'd0, sat_count}, 64'd1);
        send_one("sat_lo", 64'hFFFF_FFFF_7FFF_0000, 16'h8000);
        chk("sat_lo_cnt", {48'd0, sat_count}, 64'd2);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("sat_clr", {48'd0, sat_count}, 64'd0);
        chk("sat_clr_empty", {60'd0, fifo_level}, 64'd0);

        // Overflow: 10 samples into an 8-deep FIFO with the sink stalled
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 64'(i) << 16;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("ovf_level", {60'd0, fifo_level}, 64'd8);
        chk("ovf_drop", {48'd0, drop_count}, 64'd2);
        step();
        chk("ovf_stable", {48'd0, $unsigned(bus.data_out)}, 64'd1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovf_drain%0d", k), {48'd0, $unsigned(bus.data_out)}, 64'(k));
            step();
        end
        chk("ovf_empty_level", {60'd0, fifo_level}, 64'd0);
        chk("ovf_empty_valid", {63'd0, bus.out_valid}, 64'd0);

        // Full FIFO with simultaneous push and pop for 4 cycles
        bus.out_ready = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            bus.in_valid  = (c <= 12);
            bus.data_in   = 64'(32'h30 + c) << 16;
            bus.out_ready = (c >= 11);
            if (c >= 11) begin
                chk($sformatf("full_level_c%0d", c), {60'd0, fifo_level}, 64'd8);
                chk($sformatf("full_data_c%0d", c), {48'd0, $unsigned(bus.data_out)},
                    64'(32'h30 + c - 10));
            end
            step();
        end
        bus.in_valid = 1'b0;
        chk("full_level_end", {60'd0, fifo_level}, 64'd8);
        chk("full_drop", {48'd0, drop_count}, 64'd2);
        for (int k = 5; k <= 12; k++) begin
            chk($sformatf("full_drain%0d", k), {48'd0, $unsigned(bus.data_out)}, 64'(32'h30 + k));
            step();
        end
        chk("full_empty", {60'd0, fifo_level}, 64'd0);

        // Reset with 5 buffered and 2 in flight
        bus.out_ready = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 64'(c) << 16;
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_level", {60'd0, fifo_level}, 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_level", {60'd0, fifo_level}, 64'd0);
        chk("mid_rst_drop", {48'd0, drop_count}, 64'd0);
        chk("mid_rst_sat", {48'd0, sat_count}, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("mid_idle%0d", k), {63'd0, bus.out_valid}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iir_output_quantizer.md
Name: iir_output_quantizer

Overview:
Downstream stage of the IIR high-pass filter. It consumes the filter's 64-bit signed fixed-point output and rounds and saturates it to a 16-bit sample. Samples are buffered in a small FIFO and presented to the sink through a valid/ready handshake. It also keeps saturation and drop statistics for debug.

Parameters:
IN_W, 64, width of the signed filter output word
OUT_W, 16, width of the signed output sample
FRAC_SHIFT, 16, fractional bits to discard (0..IN_W-OUT_W)
FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, at least 2
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock (filter sample clock)
rst  in  1  synchronous, active-high reset
in_valid  in  1  data_in holds a new filter sample this cycle
data_in  in  IN_W  signed two's-complement filter output
clr_stats  in  1  clears sat_count and drop_count
out_valid  out  1  FIFO head is valid
out_ready  in  1  sink accepts the head this cycle
data_out  out  OUT_W  signed quantized sample at the FIFO head
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
sat_count  out  CNT_W  number of samples clipped
drop_count  out  CNT_W  number of samples lost because the FIFO was full

Behaviour:
- Reset (rst=1 at a rising edge):
  - pipeline valids, FIFO pointers and both counters go to 0.
  - out_valid=0, fifo_level=0, sat_count=0, drop_count=0, data_out=0.
  - Reset mid-operation discards all buffered and in-flight samples. Nothing is written to the FIFO in the 2 cycles after rst deasserts unless new in_valid inputs arrive.
- Stage 1 (edge E0, in_valid=1):
  - r = data_in + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0), computed at IN_W+1 bits so it cannot wrap.
  - Rounding is round-half-up: ties go toward +infinity.
- Stage 2 (E1):
  - q = r >>> FRAC_SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, clamp to 0x7FFF and raise sat. If q < -2^(OUT_W-1), clamp to 0x8000 and raise sat.
- FIFO write (E2): the stage-2 result is written if the FIFO is not full.
  - Full FIFO: the new sample is dropped, drop_count increments and FIFO contents are unchanged.
  - Full FIFO with a read in the same cycle (out_valid & out_ready): the read frees a slot and the write is accepted. Level stays FIFO_DEPTH and drop_count is unchanged.
- Latency: in_valid in cycle N gives out_valid=1 in cycle N+3, when the FIFO was empty and rst is low.
- Throughput: one sample per clock, sustained.
- Output side:
  - out_valid = (fifo_level != 0). data_out = head entry; it is 0 when empty.
  - A pop occurs when out_valid & out_ready at an edge. out_ready while empty has no effect.
  - data_out must stay stable while out_valid=1 and out_ready=0.
- Occupancy: fifo_level changes by +1, -1 or 0 per edge. Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - sat_count increments once per saturated sample when that sample reaches stage 2, whether or not it is later dropped.
  - Both counters stick at all-ones and never wrap.
  - clr_stats has priority over a same-cycle increment: the counter reads 0 afterwards.

Decomposition:
- iir_pkg holds:
  - default IN_W, OUT_W, FRAC_SHIFT;
  - the OUT_MAX/OUT_MIN constants;
  - the sample typedefs logic signed [IN_W-1:0] and logic signed [OUT_W-1:0].
- One sub-module, iir_sync_fifo: parameterised width and depth, synchronous rst, push/pop/full/empty/level. Its reset behaviour must match the FIFO reset rules above.
- Rounding, saturation and counters stay in the top module.

Test Plan:
1. Rounding, positive: data_in=0x0000_0000_0012_8000 (18.5), out_ready=1 -> data_out=0x0013 with out_valid high 3 cycles later. sat_count=0.
2. Rounding, negative:
   - data_in=0xFFFF_FFFF_FFFF_8000 (-0.5) -> data_out=0x0000.
   - data_in=0xFFFF_FFFF_FFFE_8000 (-1.5) -> data_out=0xFFFF (-1).
3. Saturation:
   - data_in=0x0000_0000_8000_0000 -> data_out=0x7FFF, sat_count=1.
   - then data_in=0xFFFF_FFFF_7FFF_0000 -> data_out=0x8000, sat_count=2.
   - then clr_stats=1 for one cycle -> sat_count=0.
4. Overflow: out_ready=0, 10 back-to-back in_valid samples with values 1..10 (as 1<<16 .. 10<<16) -> fifo_level=8 and drop_count=2. Then out_ready=1 drains 0x0001..0x0008 in order, and level returns to 0.
5. Full with simultaneous traffic: FIFO full, in_valid=1 and out_ready=1 for 4 cycles -> level stays 8, drop_count unchanged, outputs in order with no duplicates.
6. Reset mid-operation: fifo_level=5 and 2 samples in flight, then rst=1 for one cycle -> next cycle out_valid=0, fifo_level=0, counters 0. No out_valid appears during the following 5 idle cycles.
